// File: rtl/fmul_seq.sv
// Iterative radix-2 shift-add multiplier for the AVR MUL/FMUL/FMULS/FMULSU modes.
// Define FMUL_SAT_EN to saturate fractional-mode results instead of wrapping them.
module fmul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_rd,
    input  logic [WIDTH-1:0] i_rr,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_r1,
    output logic [WIDTH-1:0] o_r0,
    output logic             o_c,
    output logic             o_z
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [1:0] MODE_MUL    = 2'b00;
    localparam logic [1:0] MODE_FMUL   = 2'b01;
    localparam logic [1:0] MODE_FMULS  = 2'b10;
    localparam logic [1:0] MODE_FMULSU = 2'b11;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       mode_q;
    logic             neg_q;
    logic [WIDTH-1:0] mcand_q;
    logic [PW-1:0]    prod_q;

    logic             rd_signed;
    logic             rr_signed;
    logic             start_neg;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic signed [PW-1:0] raw;
    logic [PW-1:0]    res_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        // The most negative value negates onto itself, which read unsigned is 2^(WIDTH-1).
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

`ifdef FMUL_SAT_EN
    function automatic logic [PW-1:0] saturate(input logic [PW-1:0] raw_v,
                                               input logic [PW-1:0] wrapped,
                                               input logic [1:0]    mode,
                                               input logic          neg);
        logic [PW-1:0] r;
        r = wrapped;
        case (mode)
            MODE_FMUL: begin
                if (raw_v[PW-1]) r = '1;
            end
            MODE_FMULS, MODE_FMULSU: begin
                // Doubling overflows whenever the top two raw bits disagree.
                if (raw_v[PW-1] != raw_v[PW-2])
                    r = neg ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
            end
            default: ;
        endcase
        return r;
    endfunction
`endif

    assign rd_signed = i_mode[1];
    assign rr_signed = (i_mode == MODE_FMULS);
    assign start_neg = (rd_signed & i_rd[WIDTH-1]) ^ (rr_signed & i_rr[WIDTH-1]);

    always_comb begin
        addend  = prod_q[0] ? mcand_q : '0;
        sum     = {1'b0, prod_q[PW-1:WIDTH]} + {1'b0, addend};
        raw     = neg_q ? -$signed(prod_q) : $signed(prod_q);
        res_fix = (mode_q == MODE_MUL) ? raw : {raw[PW-2:0], 1'b0};
`ifdef FMUL_SAT_EN
        res_fix = saturate(raw, res_fix, mode_q, neg_q);
`endif
    end

    assign o_busy = (state != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            o_done <= 1'b0;
            o_r1   <= '0;
            o_r0   <= '0;
            o_c    <= 1'b0;
            o_z    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        mode_q  <= i_mode;
                        neg_q   <= start_neg;
                        mcand_q <= magnitude(i_rd, rd_signed);
                        prod_q  <= {{WIDTH{1'b0}}, magnitude(i_rr, rr_signed)};
                        cnt     <= '0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Accumulator high half takes the carry; the multiplier shifts out below it.
                    prod_q <= {sum, prod_q[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    o_r1   <= res_fix[PW-1:WIDTH];
                    o_r0   <= res_fix[WIDTH-1:0];
                    o_c    <= raw[PW-1];
                    o_z    <= (res_fix == '0);
                    o_done <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_seq.sv
// Self-checking bench for fmul_seq: directed cases from the test plan plus randomized
// traffic, all checked every cycle against a product-level reference model.
module tb_fmul_seq;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [1:0]    i_mode;
    logic [W-1:0]  i_rd;
    logic [W-1:0]  i_rr;
    logic          o_busy;
    logic          o_done;
    logic [W-1:0]  o_r1;
    logic [W-1:0]  o_r0;
    logic          o_c;
    logic          o_z;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int busy_cnt;

    fmul_seq #(.WIDTH(W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(i_start),
        .i_mode (i_mode),
        .i_rd   (i_rd),
        .i_rr   (i_rr),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_r1   (o_r1),
        .o_r0   (o_r0),
        .o_c    (o_c),
        .o_z    (o_z)
    );

    always #5 clk = ~clk;

    // Reference: true integer product, then the architectural result rules.
    function automatic logic [PW:0] model_op(input logic [1:0] m, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, p, v;
        logic [PW-1:0] raw, res;
        sa  = m[1] ? longint'($signed(a)) : longint'(a);
        sb  = (m == 2'b10) ? longint'($signed(b)) : longint'(b);
        p   = sa * sb;
        raw = p[PW-1:0];
        if (m == 2'b00) begin
            res = raw;
        end else begin
            v   = p * 2;
            res = v[PW-1:0];
`ifdef FMUL_SAT_EN
            if (m == 2'b01 && v > ((longint'(1) << PW) - 1)) res = '1;
            if (m[1] && v > ((longint'(1) << (PW - 1)) - 1)) res = {1'b0, {(PW-1){1'b1}}};
            if (m[1] && v < -(longint'(1) << (PW - 1)))      res = {1'b1, {(PW-1){1'b0}}};
`endif
        end
        return {raw[PW-1], res};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level expectation: an accepted start delivers its result W+1 edges later.
    int            left = 0;
    logic [PW:0]   pend;
    logic          exp_done;
    logic [PW-1:0] exp_r;
    logic          exp_c;
    logic          exp_z;
    logic          exp_busy;

    assign exp_busy = (left != 0);

    always @(posedge clk) begin
        if (rst) begin
            left     <= 0;
            exp_done <= 1'b0;
            exp_r    <= '0;
            exp_c    <= 1'b0;
            exp_z    <= 1'b0;
        end else if (left > 0) begin
            left     <= left - 1;
            exp_done <= (left == 1);
            if (left == 1) begin
                exp_r <= pend[PW-1:0];
                exp_c <= pend[PW];
                exp_z <= (pend[PW-1:0] == '0);
            end
        end else begin
            exp_done <= 1'b0;
            if (i_start) begin
                pend <= model_op(i_mode, i_rd, i_rr);
                left <= W + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(o_busy), 32'(exp_busy));
            check("done", 32'(o_done), 32'(exp_done));
            check("result", 32'({o_r1, o_r0}), 32'(exp_r));
            check("carry", 32'(o_c), 32'(exp_c));
            check("zero", 32'(o_z), 32'(exp_z));
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        i_start = 1'b1;
        i_mode  = m;
        i_rd    = a;
        i_rr    = b;
        @(negedge clk);
        i_start  = 1'b0;
        i_mode   = 2'($urandom);
        i_rd     = W'($urandom);
        i_rr     = W'($urandom);
        busy_cnt = o_busy ? 1 : 0;
    endtask

    task automatic wait_done(input int limit, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (o_busy) busy_cnt++;
            if (o_done) seen = 1'b1;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] m, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [PW-1:0] exp_res, input logic exp_cy);
        int cyc;
        bit seen;
        start_op(m, a, b);
        wait_done(40, cyc, seen);
        check({name, "_seen"}, 32'(seen), 32'd1);
        check({name, "_lat"}, 32'(cyc), 32'(W + 1));
        check({name, "_res"}, 32'({o_r1, o_r0}), 32'(exp_res));
        check({name, "_c"}, 32'(o_c), 32'(exp_cy));
    endtask

    initial begin
        int  cyc;
        bit  seen;
        rst     = 1'b1;
        i_start = 1'b0;
        i_mode  = 2'b00;
        i_rd    = '0;
        i_rr    = '0;

        // Model pinned against hand-computed products.
        check("m_fmul_4c59", 32'(model_op(2'b01, 8'h4C, 8'h59)), 32'h0_34D8);
        check("m_fmuls_40c0", 32'(model_op(2'b10, 8'h40, 8'hC0)), 32'h1_E000);
        check("m_mul_ffff", 32'(model_op(2'b00, 8'hFF, 8'hFF)), 32'h1_FE01);
`ifdef FMUL_SAT_EN
        check("m_fmuls_8080", 32'(model_op(2'b10, 8'h80, 8'h80)), 32'h0_7FFF);
`else
        check("m_fmuls_8080", 32'(model_op(2'b10, 8'h80, 8'h80)), 32'h0_8000);
`endif
        check("m_fmul_8080", 32'(model_op(2'b01, 8'h80, 8'h80)), 32'h0_8000);
        check("m_fmul_8000", 32'(model_op(2'b01, 8'h80, 8'h00)), 32'h0_0000);
        check("m_fmulsu_ff02", 32'(model_op(2'b11, 8'hFF, 8'h02)), 32'h1_FFFC);

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_res", 32'({o_r1, o_r0, o_c, o_z}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("fmul_4c59", 2'b01, 8'h4C, 8'h59, 16'h34D8, 1'b0);
        check("fmul_4c59_z", 32'(o_z), 32'd0);
        check("fmul_4c59_busy", 32'(busy_cnt), 32'(W + 1));

        run_op("fmuls_40c0", 2'b10, 8'h40, 8'hC0, 16'hE000, 1'b1);
        run_op("mul_b2b", 2'b00, 8'hFF, 8'hFF, 16'hFE01, 1'b1);
`ifdef FMUL_SAT_EN
        run_op("fmuls_8080", 2'b10, 8'h80, 8'h80, 16'h7FFF, 1'b0);
`else
        run_op("fmuls_8080", 2'b10, 8'h80, 8'h80, 16'h8000, 1'b0);
`endif
        run_op("fmul_8080", 2'b01, 8'h80, 8'h80, 16'h8000, 1'b0);
        run_op("fmul_zero", 2'b01, 8'h80, 8'h00, 16'h0000, 1'b0);
        check("fmul_zero_z", 32'(o_z), 32'd1);
        run_op("fmulsu_ff02", 2'b11, 8'hFF, 8'h02, 16'hFFFC, 1'b1);

        // A second start three cycles in must not disturb the running operation.
        start_op(2'b01, 8'h4C, 8'h59);
        repeat (2) @(negedge clk);
        i_start = 1'b1;
        i_mode  = 2'b00;
        i_rd    = 8'h11;
        i_rr    = 8'h22;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(40, cyc, seen);
        check("ign_lat", 32'(cyc + 3), 32'(W + 1));
        check("ign_res", 32'({o_r1, o_r0}), 32'h34D8);

        // Reset mid-calculation aborts the operation.
        start_op(2'b10, 8'h40, 8'hC0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_res", 32'({o_r1, o_r0, o_c, o_z}), 32'd0);
        wait_done(15, cyc, seen);
        check("abort_no_done", 32'(seen), 32'd0);
        run_op("post_abort", 2'b00, 8'hFF, 8'hFF, 16'hFE01, 1'b1);

        // Randomized traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            i_start = ($urandom_range(0, 3) == 0);
            i_mode  = 2'($urandom);
            i_rd    = W'($urandom);
            i_rr    = W'($urandom);
            rst     = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst     = 1'b0;
        i_start = 1'b0;
        repeat (20) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fmul_seq.md
Name: fmul_seq

Overview:
- Sequential, parametrised successor to the combinational 8-bit fractional multiplier.
- Iterative radix-2 shift-add multiplier covering the four AVR multiply modes: MUL, FMUL, FMULS and FMULSU.
- Result is split into high and low halves plus C/Z flags.
- Sits in the ALU/multiply path and trades one-cycle latency for area: one start/done handshake per operation.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH, split as o_r1 (high) and o_r0 (low); legal range 4..32.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_start  input  1  request; accepted only in IDLE.
- i_mode  input  2  00 MUL (unsigned, no shift); 01 FMUL (unsigned, <<1); 10 FMULS (signed x signed, <<1); 11 FMULSU (i_rd signed x i_rr unsigned, <<1).
- i_rd  input  WIDTH  multiplicand.
- i_rr  input  WIDTH  multiplier.
- o_busy  output  1  high while an operation is in progress.
- o_done  output  1  one-cycle pulse: result valid.
- o_r1  output  WIDTH  result high half.
- o_r0  output  WIDTH  result low half.
- o_c  output  1  carry: bit 2*WIDTH-1 of the raw, unshifted product.
- o_z  output  1  high when {o_r1,o_r0} == 0.

Behaviour:
- Reset: all outputs 0 and state IDLE. Reset in any state aborts the operation: no o_done, result registers cleared.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - On i_start, latch i_mode and operand magnitudes. Signed operands are two's-complement negated if their MSB is set; the result sign is the XOR of the operand signs.
  - Clear the accumulator and iteration counter, go to CALC.
- CALC: exactly WIDTH cycles. Each cycle, if multiplier LSB=1, add the multiplicand to the accumulator high half, then shift {acc, multiplier} right one bit.
- FIX: one cycle.
  - Negate the accumulator if the result sign is 1; this gives the raw product.
  - o_c = raw[2W-1].
  - Result = raw for MUL, raw<<1 (LSB 0, bit 2W-1 discarded) for the fractional modes.
  - Write o_r1/o_r0/o_c/o_z, pulse o_done, return to IDLE.
- Latency: start accepted at edge 0; o_done is high during the cycle after edge WIDTH+1 (WIDTH+2 cycles total).
- o_busy is high from the cycle after edge 0 through the FIX cycle, and low in the o_done cycle.
- i_start while busy is ignored; no queueing. i_start in the o_done cycle is accepted (back-to-back throughput).
- o_r1/o_r0/o_c/o_z hold their value until the next FIX or reset.
- Operands are sampled only at acceptance. Later changes on i_rd/i_rr/i_mode have no effect on the operation in progress.
- Width rules:
  - The accumulator is 2*WIDTH bits.
  - Magnitude of the most negative value (0x80 for WIDTH=8) is 2^(WIDTH-1), held unsigned, so no overflow before FIX.
  - Signed -1.0 x -1.0 wraps to 0x8000 in the fractional modes, matching the AVR.

Optional Feature:
- Macro: FMUL_SAT_EN.
- Defined: FIX saturates fractional-mode results instead of wrapping.
  - FMULS/FMULSU: if raw[2W-1] != raw[2W-2], result = sign ? {1,0..0} : {0,1..1}.
  - FMUL: if raw[2W-1]=1, result = all ones.
  - MUL is unaffected; o_c always reflects the unsaturated raw product; o_z is computed after saturation.
- Undefined: plain wrap, as described above.
- Latency and ports are identical in both builds.

Test Plan (WIDTH=8):
- FMUL, rd=0x4C, rr=0x59 -> o_done 10 cycles after start; r1:r0=0x34D8, c=0, z=0; o_busy high for exactly 9 cycles.
- FMULS, rd=0x40, rr=0xC0 -> r1:r0=0xE000, c=1. Then MUL, rd=0xFF, rr=0xFF, started in the o_done cycle -> r1:r0=0xFE01, c=1.
- FMULS, rd=0x80, rr=0x80 -> 0x8000, c=0 without FMUL_SAT_EN; 0x7FFF, c=0 with it. FMUL 0x80x0x80 -> 0x8000 in both builds (raw 0x4000, no saturation).
- FMUL, rd=0x80, rr=0x00 -> r1:r0=0x0000, z=1, c=0. FMULSU, rd=0xFF, rr=0x02 -> raw 0xFFFE, result 0xFFFC, c=1.
- Pulse i_start again 3 cycles into an operation with different operands -> ignored; original result delivered at the original time.
- Assert i_rst for one cycle during CALC -> next cycle o_busy=0 and outputs 0; no o_done ever follows; a new start then completes normally.
